// File: rtl/edge_detect_multi_pkg.sv
// Shared types for the multi-channel edge detector.
// Optional feature macro used by the top: EDGE_SYNC_EN (2-flop input synchroniser).
package edge_pkg;

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_PEND_HI = 2'd1,
    ST_HIGH    = 2'd2,
    ST_PEND_LO = 2'd3
  } edge_state_t;

  typedef enum logic [1:0] {
    EM_OFF  = 2'b00,
    EM_RISE = 2'b01,
    EM_FALL = 2'b10,
    EM_BOTH = 2'b11
  } edge_mode_t;

  // Filter counter width: $clog2(filt+1), never below one bit.
  function automatic int unsigned cnt_width(input int unsigned filt);
    int unsigned w;
    w = $clog2(filt + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/edge_detect_multi_chan.sv
// One edge-detector channel: level FSM with stability filter, mode
// qualification, Mealy or registered (Moore) tick/dir, sticky pending flag.
module edge_chan
  import edge_pkg::*;
#(
  parameter int unsigned FILT_CYCLES = 0,
  parameter int unsigned MOORE       = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       level,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       tick,
  output logic       dir,
  output logic       pending
);

  localparam int unsigned CW       = cnt_width(FILT_CYCLES);
  localparam bit          FILT_IMM = (FILT_CYCLES <= 1);
  localparam int unsigned LAST_INT = (FILT_CYCLES > 1) ? (FILT_CYCLES - 1) : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAST_INT);

  edge_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;

  logic       acc;
  logic       acc_dir;
  logic       qual;
  logic       qual_dir;
  edge_mode_t mode_e;
  logic       rise_en;
  logic       fall_en;

  assign mode_e  = edge_mode_t'(mode);
  assign rise_en = (mode_e == EM_RISE) || (mode_e == EM_BOTH);
  assign fall_en = (mode_e == EM_FALL) || (mode_e == EM_BOTH);

  // Next-state, filter counter and acceptance decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc     = 1'b0;
    acc_dir = 1'b0;
    unique case (state_q)
      ST_LOW: begin
        if (level) begin
          if (FILT_IMM) begin
            acc     = 1'b1;
            acc_dir = 1'b1;
            state_d = ST_HIGH;
          end else begin
            cnt_d   = CW'(1);
            state_d = ST_PEND_HI;
          end
        end
      end
      ST_PEND_HI: begin
        if (!level) begin
          cnt_d   = '0;
          state_d = ST_LOW;
        end else if (cnt_q == CNT_LAST) begin
          acc     = 1'b1;
          acc_dir = 1'b1;
          cnt_d   = '0;
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HIGH: begin
        if (!level) begin
          if (FILT_IMM) begin
            acc     = 1'b1;
            acc_dir = 1'b0;
            state_d = ST_LOW;
          end else begin
            cnt_d   = CW'(1);
            state_d = ST_PEND_LO;
          end
        end
      end
      ST_PEND_LO: begin
        if (level) begin
          cnt_d   = '0;
          state_d = ST_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          acc     = 1'b1;
          acc_dir = 1'b0;
          cnt_d   = '0;
          state_d = ST_LOW;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_LOW;
      end
    endcase
  end

  // Qualify the accepted edge against the mode and update the sticky flag
  always_comb begin
    qual      = acc && (acc_dir ? rise_en : fall_en);
    qual_dir  = qual && acc_dir;
    pending_d = qual | (pending_q & ~clr);
  end

  // Channel state, filter counter and pending registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_LOW;
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

  generate
    if (MOORE != 0) begin : g_moore
      logic tick_q, tick_d;
      logic dir_q, dir_d;

      // Registered copy of the Mealy terms
      always_comb begin
        tick_d = qual;
        dir_d  = qual_dir;
      end

      // Moore output registers
      always_ff @(posedge clk) begin
        if (reset) begin
          tick_q <= 1'b0;
          dir_q  <= 1'b0;
        end else begin
          tick_q <= tick_d;
          dir_q  <= dir_d;
        end
      end

      assign tick = tick_q;
      assign dir  = dir_q;
    end else begin : g_mealy
      assign tick = qual;
      assign dir  = qual_dir;
    end
  endgenerate

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector top: optional input synchroniser, CH channel
// instances and the any_pending reduction.
// Define EDGE_SYNC_EN to insert a 2-flop synchroniser on every level bit.
module edge_detect_multi
  import edge_pkg::*;
#(
  parameter int unsigned CH          = 4,
  parameter int unsigned FILT_CYCLES = 0,
  parameter int unsigned MOORE       = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CH-1:0]   level,
  input  logic [2*CH-1:0] mode,
  input  logic [CH-1:0]   clr,
  output logic [CH-1:0]   tick,
  output logic [CH-1:0]   dir,
  output logic [CH-1:0]   pending,
  output logic            any_pending
);

  logic [CH-1:0] level_s;

`ifdef EDGE_SYNC_EN
  logic [CH-1:0] sync1_q, sync1_d;
  logic [CH-1:0] sync2_q, sync2_d;

  // Synchroniser shift
  always_comb begin
    sync1_d = level;
    sync2_d = sync1_q;
  end

  // Two-stage synchroniser flops
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign level_s = sync2_q;
`else
  assign level_s = level;
`endif

  generate
    for (genvar i = 0; i < int'(CH); i++) begin : g_chan
      edge_chan #(
        .FILT_CYCLES (FILT_CYCLES),
        .MOORE       (MOORE)
      ) u_chan (
        .clk     (clk),
        .reset   (reset),
        .level   (level_s[i]),
        .mode    (mode[2*i+1:2*i]),
        .clr     (clr[i]),
        .tick    (tick[i]),
        .dir     (dir[i]),
        .pending (pending[i])
      );
    end
  endgenerate

  assign any_pending = |pending;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Self-checking bench for edge_detect_multi: three instances (FILT 0 Mealy,
// FILT 4 Mealy, FILT 4 Moore) share stimulus; a run-length reference model
// pushes expected outputs to a scoreboard that is popped after each cycle.
module tb_edge_detect_multi;

`ifdef EDGE_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] level;
  logic [7:0] mode;
  logic [3:0] clr;

  logic [3:0] tick_o [3];
  logic [3:0] dir_o  [3];
  logic [3:0] pend_o [3];
  logic       any_o  [3];

  always #5 clk = ~clk;

  edge_detect_multi #(.CH(4), .FILT_CYCLES(0), .MOORE(0)) dut_f0 (
    .clk(clk), .reset(reset), .level(level), .mode(mode), .clr(clr),
    .tick(tick_o[0]), .dir(dir_o[0]), .pending(pend_o[0]), .any_pending(any_o[0]));

  edge_detect_multi #(.CH(4), .FILT_CYCLES(4), .MOORE(0)) dut_f4 (
    .clk(clk), .reset(reset), .level(level), .mode(mode), .clr(clr),
    .tick(tick_o[1]), .dir(dir_o[1]), .pending(pend_o[1]), .any_pending(any_o[1]));

  edge_detect_multi #(.CH(4), .FILT_CYCLES(4), .MOORE(1)) dut_f4m (
    .clk(clk), .reset(reset), .level(level), .mode(mode), .clr(clr),
    .tick(tick_o[2]), .dir(dir_o[2]), .pending(pend_o[2]), .any_pending(any_o[2]));

  typedef struct {
    int         inst;
    logic [3:0] tick;
    logic [3:0] dir;
    logic [3:0] pend;
    logic       any;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model: accepted level plus run length of differing samples
  logic       m_acc [3][4];
  int         m_run [3][4];
  logic [3:0] m_pend [3];
  logic [3:0] m_mtick [3];
  logic [3:0] m_mdir [3];
  logic [3:0] s1, s2;

  function automatic int filt_of(input int i);
    return (i == 0) ? 0 : 4;
  endfunction

  function automatic bit moore_of(input int i);
    return (i == 2);
  endfunction

  task automatic chk(input string tag, input int inst, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s[%0d] t=%0t observed=%b expected=%b", tag, inst, $time, obs, exp);
  endtask

  task automatic step(input logic [3:0] lv, input logic [7:0] md, input logic [3:0] cl, input logic rst);
    logic [3:0] eff;
    logic [3:0] qa  [3];
    logic [3:0] qda [3];
    exp_t e;
    int need;
    bit edg;
    bit en;
    @(posedge clk);
    #1;
    level = lv;
    mode  = md;
    clr   = cl;
    reset = rst;
    eff = SYNC ? s2 : lv;
    for (int i = 0; i < 3; i++) begin
      qa[i]  = '0;
      qda[i] = '0;
      need = (filt_of(i) <= 1) ? 1 : filt_of(i);
      for (int c = 0; c < 4; c++) begin
        edg = (eff[c] != m_acc[i][c]) && (m_run[i][c] + 1 >= need);
        en  = eff[c] ? md[2*c] : md[2*c+1];
        qa[i][c]  = edg && en;
        qda[i][c] = edg && en && eff[c];
      end
      e.inst = i;
      e.tick = moore_of(i) ? m_mtick[i] : qa[i];
      e.dir  = moore_of(i) ? m_mdir[i]  : qda[i];
      e.pend = m_pend[i];
      e.any  = |m_pend[i];
      if (!rst) sb.push_back(e);
    end
    #3;
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        e = sb.pop_front();
        chk("tick",    e.inst, tick_o[e.inst], e.tick);
        chk("dir",     e.inst, dir_o[e.inst],  e.dir);
        chk("pending", e.inst, pend_o[e.inst], e.pend);
        chk("any",     e.inst, {3'b000, any_o[e.inst]}, {3'b000, e.any});
      end
    end
    for (int i = 0; i < 3; i++) begin
      need = (filt_of(i) <= 1) ? 1 : filt_of(i);
      if (rst) begin
        for (int c = 0; c < 4; c++) begin
          m_acc[i][c] = 1'b0;
          m_run[i][c] = 0;
        end
        m_pend[i]  = '0;
        m_mtick[i] = '0;
        m_mdir[i]  = '0;
      end else begin
        for (int c = 0; c < 4; c++) begin
          if (eff[c] != m_acc[i][c]) begin
            if (m_run[i][c] + 1 >= need) begin
              m_acc[i][c] = eff[c];
              m_run[i][c] = 0;
            end else begin
              m_run[i][c] = m_run[i][c] + 1;
            end
          end else begin
            m_run[i][c] = 0;
          end
        end
        m_pend[i]  = qa[i] | (m_pend[i] & ~cl);
        m_mtick[i] = qa[i];
        m_mdir[i]  = qda[i];
      end
    end
    s2 = rst ? 4'b0 : s1;
    s1 = rst ? 4'b0 : lv;
  endtask

  task automatic hold(input logic [3:0] lv, input logic [7:0] md, input logic [3:0] cl, input int n);
    for (int k = 0; k < n; k++) step(lv, md, cl, 1'b0);
  endtask

  initial begin
    level = '0;
    mode  = 8'h55;
    clr   = '0;
    reset = 1'b1;
    s1 = '0;
    s2 = '0;
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = '0; m_mtick[i] = '0; m_mdir[i] = '0;
      for (int c = 0; c < 4; c++) begin
        m_acc[i][c] = 1'b0;
        m_run[i][c] = 0;
      end
    end

    // reset and idle reset-state checks
    for (int k = 0; k < 3; k++) step(4'h0, 8'h55, 4'h0, 1'b1);
    hold(4'h0, 8'h55, 4'h0, 3);

    // basic rise on ch0, fall gives no tick in rising mode
    hold(4'h1, 8'h55, 4'h0, 8);
    hold(4'h0, 8'h55, 4'h0, 8);

    // both-edge toggle on ch1
    for (int k = 0; k < 6; k++) step((k % 2 == 0) ? 4'h2 : 4'h0, 8'h5D, 4'h0, 1'b0);
    hold(4'h0, 8'h5D, 4'h0, 8);

    // filter rejection: 3-, 4- and 5-cycle pulses on ch0
    hold(4'h1, 8'h55, 4'h0, 3);
    hold(4'h0, 8'h55, 4'h0, 6);
    hold(4'h1, 8'h55, 4'h0, 4);
    hold(4'h0, 8'h55, 4'h0, 6);
    hold(4'h1, 8'h55, 4'h0, 5);
    hold(4'h0, 8'h55, 4'h0, 8);

    // clear collision on ch2
    step(4'h0, 8'h55, 4'hF, 1'b0);
    hold(4'h4, 8'h55, 4'h0, 6);
    hold(4'h0, 8'h55, 4'h0, 6);
    hold(4'h4, 8'h55, 4'h4, 5);
    step(4'h4, 8'h55, 4'h4, 1'b0);
    hold(4'h4, 8'h55, 4'h0, 2);
    step(4'h4, 8'h55, 4'hF, 1'b0);
    hold(4'h0, 8'h55, 4'h0, 6);

    // reset during pending-high with level held high
    hold(4'h1, 8'h55, 4'h0, 3);
    step(4'h1, 8'h55, 4'h0, 1'b1);
    hold(4'h1, 8'h55, 4'h0, 7);
    hold(4'h0, 8'h55, 4'h0, 6);

    // mode off on ch3, then switch to falling while high
    hold(4'h8, 8'h15, 4'h0, 6);
    hold(4'h0, 8'h15, 4'h0, 6);
    hold(4'h8, 8'h15, 4'h0, 6);
    hold(4'h8, 8'h95, 4'h0, 3);
    hold(4'h0, 8'h95, 4'h0, 8);

    // random mix of levels, modes and clears
    for (int k = 0; k < 60; k++)
      step(4'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, 1'b0);
    hold(4'h0, 8'h55, 4'h0, 8);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
